// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the master (requester) and the register-file slave.
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0). It is
// followed by access cycles (PSEL=1, PENABLE=1) until the slave drives PREADY=1.
// The transfer completes on the rising edge where PSEL & PENABLE & PREADY all
// hold. PRDATA and PSLVERR are meaningful only while PREADY=1.
interface apb_slave_regfile_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB slave backed by a DEPTH-entry register file.
// - Inserts WAIT_STATES PREADY-low cycles in ACCESS.
// - Flags out-of-range addresses with PSLVERR.
// - Counts completed transfers.
// PRESETn is active-high and asynchronous, despite its name.
module apb_slave_regfile #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  apb_slave_regfile_if.slave bus,
  output logic [15:0] xfer_count,
  output logic        state_dbg
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT_STATES);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic              err_q;
  logic [3:0]        wcnt_q;
  logic              ready;
  logic              setup;
  logic              complete;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // Only in-range addresses ever reach the array, so the low bits suffice.
  assign idx       = addr_q[IDX_W-1:0];
  assign ready     = (state_q == ACCESS) && (wcnt_q == 4'd0);
  assign state_dbg = (state_q == ACCESS);

  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready && err_q;
  assign bus.PRDATA  = (ready && !wr_q && !err_q) ? mem[idx] : '0;

  // State register.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and the setup/completion strobes.
  // Dropping PSEL in ACCESS aborts the transfer.
  always_comb begin
    state_d  = state_q;
    setup    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          setup   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
        end else if (bus.PENABLE && ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer context: latched at setup, wait count runs down during access.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      addr_q     <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      wcnt_q     <= 4'd0;
      xfer_count <= 16'd0;
    end else begin
      if (setup) begin
        addr_q <= bus.PADDR;
        wr_q   <= bus.PWRITE;
        err_q  <= ({1'b0, bus.PADDR} >= DEPTH_L);
        wcnt_q <= WAIT_L;
      end else if ((state_q == ACCESS) && bus.PSEL && bus.PENABLE && (wcnt_q != 4'd0)) begin
        wcnt_q <= wcnt_q - 4'd1;
      end
      if (complete) xfer_count <= xfer_count + 16'd1;
    end
  end

  // Register file: a write commits only on its completion edge.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (complete && wr_q && !err_q) begin
      mem[idx] <= bus.PWDATA;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile.
// dut0 runs with one wait state and dut1 with zero wait states.
// Both are compared against an array model of the register file and counter.
module tb_apb_slave_regfile;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b1;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Shared stimulus; tgt steers PSEL to one of the two slaves.
  bit         tgt = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'h00, pwdata = 8'h00;

  apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(8)) if0 ();
  apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(8)) if1 ();

  assign if0.PSEL = psel & ~tgt;
  assign if1.PSEL = psel & tgt;
  assign if0.PENABLE = penable;
  assign if1.PENABLE = penable;
  assign if0.PWRITE = pwrite;
  assign if1.PWRITE = pwrite;
  assign if0.PADDR = paddr;
  assign if1.PADDR = paddr;
  assign if0.PWDATA = pwdata;
  assign if1.PWDATA = pwdata;

  logic [15:0] cnt0, cnt1;
  logic        st0, st1;

  apb_slave_regfile #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_STATES(1)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(if0.slave), .xfer_count(cnt0), .state_dbg(st0));
  apb_slave_regfile #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_STATES(0)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(if1.slave), .xfer_count(cnt1), .state_dbg(st1));

  wire        o_ready = tgt ? if1.PREADY : if0.PREADY;
  wire        o_err   = tgt ? if1.PSLVERR : if0.PSLVERR;
  wire [7:0]  o_rdata = tgt ? if1.PRDATA : if0.PRDATA;
  wire [15:0] o_count = tgt ? cnt1 : cnt0;
  wire        o_state = tgt ? st1 : st0;

  // Reference model: register contents and completed-transfer count per slave.
  logic [7:0] model_mem [2][64];
  int         model_cnt [2];
  int         checks = 0;
  int         failures = 0;
  int         last_done = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) model_mem[d][i] = 8'h00;
      model_cnt[d] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    psel = 1'b0;
    penable = 1'b0;
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  // One complete transfer. Addr/dir are scrambled during the access phase,
  // since only the setup-edge values may count. PSEL stays high afterwards,
  // so the next call can follow back-to-back.
  task automatic do_xfer(input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
    int         waits;
    bit         exp_err;
    logic [7:0] exp_rd;
    logic [7:0] rd;
    logic       er;
    psel = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = addr;
    pwdata = wdata;
    @(posedge PCLK);
    #1;
    penable = 1'b1;
    paddr = 8'($urandom);
    pwrite = 1'($urandom);
    waits = 0;
    while (!o_ready && waits < 40) begin
      @(posedge PCLK);
      #1;
      waits++;
    end
    rd = o_rdata;
    er = o_err;
    exp_err = (addr >= 8'd64);
    exp_rd = (!wr && !exp_err) ? model_mem[tgt][addr[5:0]] : 8'h00;
    chk("wait_states", waits, tgt ? 0 : 1);
    chk("prdata", rd, exp_rd);
    chk("pslverr", er, exp_err);
    @(posedge PCLK);
    #1;
    last_done = cyc;
    if (wr && !exp_err) model_mem[tgt][addr[5:0]] = wdata;
    model_cnt[tgt] = (model_cnt[tgt] + 1) % 65536;
    chk("xfer_count", o_count, model_cnt[tgt]);
  endtask

  initial begin
    int first_done;
    model_reset();

    // Reset state.
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_pready", if0.PREADY, 0);
    chk("rst_prdata", if0.PRDATA, 0);
    chk("rst_pslverr", if0.PSLVERR, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_state", st0, 0);
    PRESETn = 1'b0;
    idle(1);

    // Basic write/read and an untouched address.
    tgt = 1'b0;
    do_xfer(1'b1, 8'h02, 8'hA5);
    do_xfer(1'b0, 8'h02, 8'h00);
    do_xfer(1'b0, 8'h10, 8'h00);
    idle(1);

    // Out-of-range write and read.
    do_xfer(1'b1, 8'h40, 8'h3C);
    do_xfer(1'b0, 8'h00, 8'h00);
    do_xfer(1'b0, 8'h40, 8'h00);
    do_xfer(1'b0, 8'hFF, 8'h00);
    idle(2);

    // Back-to-back write then read of the same address.
    do_xfer(1'b1, 8'h05, 8'h11);
    first_done = last_done;
    do_xfer(1'b0, 8'h05, 8'h00);
    chk("b2b_latency", last_done - first_done, 3);
    idle(1);

    // Abort: PSEL drops during the wait cycle.
    psel = 1'b1;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h06;
    pwdata = 8'h77;
    @(posedge PCLK);
    #1;
    penable = 1'b1;
    chk("abort_wait_pready", o_ready, 0);
    psel = 1'b0;
    penable = 1'b0;
    @(posedge PCLK);
    #1;
    chk("abort_state", o_state, 0);
    chk("abort_pready", o_ready, 0);
    chk("abort_count", o_count, model_cnt[0]);
    idle(1);
    chk("abort_pready_late", o_ready, 0);
    do_xfer(1'b0, 8'h06, 8'h00);
    idle(1);

    // Reset asserted between edges during the access of a write.
    psel = 1'b1;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h01;
    pwdata = 8'hFF;
    @(posedge PCLK);
    #1;
    penable = 1'b1;
    #2;
    PRESETn = 1'b1;
    #1;
    chk("midrst_pready", o_ready, 0);
    chk("midrst_count", o_count, 0);
    chk("midrst_state", o_state, 0);
    psel = 1'b0;
    penable = 1'b0;
    @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    model_reset();
    idle(1);
    do_xfer(1'b0, 8'h01, 8'h00);
    do_xfer(1'b0, 8'h02, 8'h00);
    idle(1);

    // Zero-wait slave: 2-cycle write and read.
    tgt = 1'b1;
    idle(1);
    do_xfer(1'b1, 8'h07, 8'h5A);
    first_done = last_done;
    do_xfer(1'b0, 8'h07, 8'h00);
    chk("zw_b2b_latency", last_done - first_done, 2);
    do_xfer(1'b1, 8'h3F, 8'hC3);
    do_xfer(1'b0, 8'h3F, 8'h00);
    idle(1);

    // Randomized traffic on both slaves.
    for (int n = 0; n < 120; n++) begin
      tgt = 1'($urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      do_xfer(1'($urandom), 8'($urandom_range(0, 79)), 8'($urandom));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
